seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider. It is the inverse-operation companion to the team's combinational add/subtract datapath. Each cycle performs one trial subtraction (remainder minus divisor) and keeps or discards the result based on the borrow. It sits behind a valid/ready request interface and presents quotient and remainder on a valid/ready response interface.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
dividend  input  WIDTH  unsigned dividend, sampled on request handshake
divisor  input  WIDTH  unsigned divisor, sampled on request handshake
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  result was produced from divisor == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset mid-CALC or mid-DONE aborts the operation; no result is emitted.
- Request handshake: in_valid && in_ready at a rising edge. in_ready = (state==IDLE) only; in_valid while busy is ignored.
- States:
  - IDLE: on handshake with divisor!=0, latch dividend/divisor, clear partial remainder (WIDTH+1 bits), counter=0, go to CALC. On handshake with divisor==0, go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - CALC: one iteration per edge:
    - shift {rem, q} left by 1, bringing the dividend MSB into rem LSB;
    - compute trial = rem - divisor in WIDTH+1 bits (add of inverted divisor with carry-in 1);
    - if trial is non-negative (MSB 0), rem=trial and the new quotient bit is 1; otherwise keep rem and the new quotient bit is 0.
    - After WIDTH iterations (counter==WIDTH-1 at the edge), load quotient/remainder outputs, set div_by_zero=0, go to DONE.
  - DONE: out_valid=1. On out_valid && out_ready go to IDLE. out_valid then drops and in_ready rises the following cycle.
- Latency: request accepted at edge N. out_valid is high after edge N+WIDTH for divisor!=0, and after edge N for divisor==0.
- Throughput: one operation in flight. No new request is accepted in the same cycle the result is consumed.
- Output stability: quotient, remainder and div_by_zero are held constant while out_valid=1 and out_ready=0. They keep their last values after consumption until the next result loads.
- Invariants for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Arithmetic is unsigned throughout. The partial remainder is WIDTH+1 bits to hold the borrow; only its low WIDTH bits reach the remainder port.
- Edge cases:
  - dividend=0 gives q=0, r=0.
  - divisor=1 gives q=dividend, r=0.
  - divisor>dividend gives q=0, r=dividend.
  - dividend=divisor gives q=1, r=0.
  - The all-ones/all-ones result must not overflow the partial remainder.

Test Plan:
1. WIDTH=4, reset then dividend=13, divisor=4, out_ready=1 -> out_valid rises after edge N+4; quotient=3, remainder=1, div_by_zero=0; in_ready back to 1 one cycle after consumption.
2. Corner sweep, WIDTH=4:
   - 15/1 -> q=15, r=0
   - 3/7 -> q=0, r=3
   - 15/15 -> q=1, r=0
   - 0/5 -> q=0, r=0
   - exhaustive 256 pairs (divisor!=0) check q*d+r==n and r<d.
3. Divide by zero: 9/0 -> out_valid after edge N, quotient=15, remainder=9, div_by_zero=1. A following 8/2 -> q=4, r=0, div_by_zero=0.
4. Backpressure: 13/4 with out_ready=0 for 5 cycles after out_valid -> out_valid and outputs stay at 3/1/0 every cycle; consumed on the first edge with out_ready=1.
5. Busy interlock: pulse in_valid with 6/3 during CALC of 13/4 -> in_ready=0, request ignored, result is 3/1 and no second out_valid occurs.
6. Reset mid-CALC: assert rst_n=0 two cycles into 13/4 -> all outputs return to reset values immediately, no out_valid; after release, 10/3 -> q=3, r=1.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider behind valid/ready request and response handshakes.
// One trial subtraction per cycle; a zero divisor short-circuits straight to a flagged result.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem_p0;
    logic [WIDTH-1:0]   qsh_p0;
    logic [WIDTH-1:0]   dvsr_p0;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   qsh_nxt;
    logic               accept;
    logic               last;

    // Partial remainder minus divisor in WIDTH+1 bits: add inverted divisor with carry-in.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   a,
                                                 input logic [WIDTH-1:0] b);
        return a + ~{1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CNT_W'(WIDTH - 1));

    // The restored remainder always stays below the divisor, so only its low
    // WIDTH bits are stored; the extra borrow bit lives in shifted/trial only.
    always_comb begin
        shifted = {rem_p0, qsh_p0[WIDTH-1]};
        trial   = trial_sub(shifted, dvsr_p0);
        if (trial[WIDTH]) begin
            rem_nxt = shifted[WIDTH-1:0];
            qsh_nxt = {qsh_p0[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = trial[WIDTH-1:0];
            qsh_nxt = {qsh_p0[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    quotient    <= qsh_nxt;
                    remainder   <= rem_nxt;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    // ---- iteration datapath (no reset: always reloaded on accept) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_p0  <= '0;
            qsh_p0  <= dividend;
            dvsr_p0 <= divisor;
        end else if (state == CALC) begin
            rem_p0 <= rem_nxt;
            qsh_p0 <= qsh_nxt;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=4): vector table, exhaustive and random sweeps against an
// arithmetic reference, plus hand-built busy, backpressure and reset-abort sequences.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int d;
        int q;
        int r;
        int dz;
        int hold;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ref_div(input int n, input int d, output int q, output int r, output int dz);
        if (d == 0) begin
            q = (1 << W) - 1; r = n; dz = 1;
        end else begin
            q = n / d; r = n % d; dz = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int q, input int r, input int dz);
        check({tag, "_q"}, int'(quotient), q);
        check({tag, "_r"}, int'(remainder), r);
        check({tag, "_dz"}, int'(div_by_zero), dz);
    endtask

    // One full transaction; assumes the caller sits #1 after a rising edge.
    task automatic run_op(input int n, input int d, input int q, input int r,
                          input int dz, input int hold, input string tag);
        int waited;
        int lat;
        waited = 0;
        while (!in_ready && waited < 50) begin tick(); waited++; end
        check({tag, "_in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1; dividend = W'(n); divisor = W'(d);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check({tag, "_latency"}, lat, (d == 0) ? 0 : W);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check_outs({tag, "_hold"}, q, r, dz);
            tick();
        end
        check({tag, "_valid"}, int'(out_valid), 1);
        check_outs(tag, q, r, dz);
        if (d != 0) begin
            check({tag, "_inv_eq"}, int'(quotient) * d + int'(remainder), n);
            check({tag, "_inv_lt"}, int'(int'(remainder) < d), 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, int'(out_valid), 0);
        check({tag, "_post_ready"}, int'(in_ready), 1);
        check_outs({tag, "_kept"}, q, r, dz);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eq, er, ez, n, d, cnt_v;

        vecs[0] = '{13, 4,  3, 1, 0, 0};
        vecs[1] = '{15, 1, 15, 0, 0, 0};
        vecs[2] = '{ 3, 7,  0, 3, 0, 0};
        vecs[3] = '{15, 15, 1, 0, 0, 0};
        vecs[4] = '{ 0, 5,  0, 0, 0, 0};
        vecs[5] = '{ 9, 0, 15, 9, 1, 0};
        vecs[6] = '{ 8, 2,  4, 0, 0, 0};
        vecs[7] = '{13, 4,  3, 1, 0, 5};
        vecs[8] = '{10, 3,  3, 1, 0, 2};
        vecs[9] = '{ 1, 15, 0, 1, 0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check_outs("rst", 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].hold,
                   $sformatf("vec%0d", i));

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_div(a, b, eq, er, ez);
                run_op(a, b, eq, er, ez, 0, $sformatf("ex%0d_%0d", a, b));
            end
        end

        for (int k = 0; k < 60; k++) begin
            n = int'($urandom_range(15, 0));
            d = int'($urandom_range(15, 0));
            ref_div(n, d, eq, er, ez);
            run_op(n, d, eq, er, ez, int'($urandom_range(3, 0)), $sformatf("rnd%0d", k));
        end

        // Busy interlock: a request during CALC must be ignored.
        in_valid = 1'b1; dividend = 4'd13; divisor = 4'd4;
        tick();
        in_valid = 1'b0;
        tick();
        check("busy_in_ready", int'(in_ready), 0);
        in_valid = 1'b1; dividend = 4'd6; divisor = 4'd3;
        tick();
        in_valid = 1'b0;
        cnt_v = 0;
        while (!out_valid && cnt_v < 50) begin tick(); cnt_v++; end
        check("busy_valid", int'(out_valid), 1);
        check_outs("busy", 3, 1, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) cnt_v++;
            tick();
        end
        check("busy_no_second", cnt_v, 0);

        // Reset two cycles into a calculation aborts it.
        in_valid = 1'b1; dividend = 4'd13; divisor = 4'd4;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check_outs("abort", 0, 0, 0);
        tick();
        rst_n = 1'b1;
        cnt_v = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) cnt_v++;
            tick();
        end
        check("abort_no_result", cnt_v, 0);
        run_op(10, 3, 3, 1, 0, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
